// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-requester memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY, RESP)
//   grant_e     : which requester owns the current/last access
//   pick_grant  : round-robin choice between fetch and data requesters
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  // Default number of BUSY cycles to wait for mem_ack before giving up.
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  // Width of the wait counter; wide enough for the full 2..255 timeout range.
  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_e;

  // Round-robin pick: with both requesters asking, the one that was not
  // granted last wins. A lone requester always wins. The result is only
  // meaningful when at least one request is asserted.
  function automatic grant_e pick_grant(input logic   if_req,
                                        input logic   d_req,
                                        input grant_e last_grant);
    grant_e winner;
    if (if_req && d_req) begin
      winner = (last_grant == GRANT_D) ? GRANT_IF : GRANT_D;
    end else if (if_req) begin
      winner = GRANT_IF;
    end else begin
      winner = GRANT_D;
    end
    return winner;
  endfunction

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// -----------------------------------------------------------------------------
// wait_timer
// Counts cycles spent waiting for a memory acknowledge and flags when the
// count is about to reach the programmed limit.
// Ports:
//   clk     : clock, rising edge
//   arst    : asynchronous active-low reset, clears the count
//   clear   : synchronous clear (held while the arbiter is not waiting)
//   count   : advance the count by one this cycle
//   limit   : number of counted cycles after which the wait has expired
//   expired : high in the cycle whose count brings the total to limit
// -----------------------------------------------------------------------------
module wait_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned W = WAIT_CNT_W
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         clear,
  input  logic         count,
  input  logic [W-1:0] limit,
  output logic         expired
);

  localparam logic [W-1:0] One = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over count so a fresh wait always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + One;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expired is flagged in the cycle that is being counted as the limit-th,
  // so the owner can leave its wait state on that same edge.
  assign expired = count && !clear && ((cnt_q + One) == limit);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a single memory port between an instruction-fetch requester and
// a load/store requester. One access is in flight at a time; the FSM walks
// IDLE -> BUSY -> RESP -> IDLE, with a wait-counter timeout in BUSY.
// Ports:
//   clk, arst            : clock (rising edge) and async active-low reset
//   if_req, if_addr      : fetch request (level) and address
//   if_rdata, if_done    : fetched word and one-cycle completion pulse
//   d_req, d_we          : data request (level), 1 = store / 0 = load
//   d_addr, d_wdata      : data address and store data
//   d_rdata, d_done      : load data and one-cycle completion pulse
//   mem_req, mem_we      : registered memory request and write enable
//   mem_addr, mem_wdata  : registered memory address and write data
//   mem_rdata, mem_ack   : memory read data and access-complete strobe
//   stall                : pipeline hold while a request waits for its done
//   bus_err              : access timed out, valid alongside the done pulse
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          arst,
  // Fetch requester
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  // Data requester
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  // Memory side
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  // Status
  output logic          stall,
  output logic          bus_err
);

  localparam logic [WAIT_CNT_W-1:0] TimeoutLimit = WAIT_CNT_W'(TIMEOUT);

  // FSM and grant tracking
  arb_state_e state_q, state_d;
  grant_e     grant_q, grant_d;

  // Access latched at grant time
  logic [AW-1:0] addr_q,  addr_d;
  logic          we_q,    we_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // Requester read data holding registers
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q,  d_rdata_d;

  // Registered memory-side outputs
  logic          mem_req_q,   mem_req_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  // Registered completion status
  logic if_done_q, if_done_d;
  logic d_done_q,  d_done_d;
  logic bus_err_q, bus_err_d;

  // Wait timer control
  logic timer_clear;
  logic timer_count;
  logic timer_expired;

  // The timer only runs while an access is outstanding; everywhere else it is
  // held clear so each BUSY visit starts counting from zero.
  assign timer_clear = (state_q != BUSY);
  assign timer_count = (state_q == BUSY) && !mem_ack;

  wait_timer #(
    .W (WAIT_CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .arst    (arst),
    .clear   (timer_clear),
    .count   (timer_count),
    .limit   (TimeoutLimit),
    .expired (timer_expired)
  );

  // Next-state logic. Requests are only looked at in IDLE and mem_ack only in
  // BUSY, so a requester holding its level through BUSY/RESP is harmless.
  // On a timeout the read data registers are deliberately left untouched.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    bus_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          grant_d = pick_grant(if_req, d_req, grant_q);
          if (grant_d == GRANT_IF) begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end else begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end
          state_d = BUSY;
        end
      end

      BUSY: begin
        // An ack in the same cycle as the timeout still counts as success.
        if (mem_ack) begin
          if (!we_q) begin
            if (grant_q == GRANT_IF) begin
              if_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = mem_rdata;
            end
          end
          state_d = RESP;
        end else if (timer_expired) begin
          bus_err_d = 1'b1;
          state_d   = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory and completion outputs are computed from the next state so they
  // can be registered and line up exactly with the state they belong to:
  // the memory request is live only in BUSY, the done pulse only in RESP.
  always_comb begin
    mem_req_d   = (state_d == BUSY);
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (mem_req_d) begin
      mem_we_d    = we_d;
      mem_addr_d  = addr_d;
      mem_wdata_d = wdata_d;
    end
    if_done_d = (state_d == RESP) && (grant_d == GRANT_IF);
    d_done_d  = (state_d == RESP) && (grant_d == GRANT_D);
  end

  // State and datapath registers. Reset leaves the grant pointing at data so
  // fetch wins the first contention, and kills any access in flight without
  // producing a done pulse.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= IDLE;
      grant_q     <= GRANT_D;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign bus_err   = bus_err_q;

  // Stall drops in the done cycle so the requester can retire its request.
  assign stall = (if_req || d_req) && !(if_done_q || d_done_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: single fetch, store with wait states,
// round-robin contention, timeout, ack on the last allowed cycle and a reset
// in the middle of an access.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        arst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        bus_err;

  int checkCount = 0;
  int errorCount = 0;

  mem_arbiter #(
    .AW      (32),
    .DW      (32),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .bus_err   (bus_err)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Step to just after the next rising edge, where outputs are stable.
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive both requester interfaces in one go.
  task automatic applyStimulus(input logic        ifReq,
                               input logic [31:0] ifAddr,
                               input logic        dReq,
                               input logic        dWe,
                               input logic [31:0] dAddr,
                               input logic [31:0] dWdata);
    if_req  = ifReq;
    if_addr = ifAddr;
    d_req   = dReq;
    d_we    = dWe;
    d_addr  = dAddr;
    d_wdata = dWdata;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string       tag,
                             input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int reqCycles;

    // ---------------- reset ----------------
    arst      = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    waitCycle();
    waitCycle();
    checkOutput("rst_mem_req",   mem_req,   64'd0);
    checkOutput("rst_mem_we",    mem_we,    64'd0);
    checkOutput("rst_mem_addr",  mem_addr,  64'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 64'd0);
    checkOutput("rst_if_rdata",  if_rdata,  64'd0);
    checkOutput("rst_d_rdata",   d_rdata,   64'd0);
    checkOutput("rst_if_done",   if_done,   64'd0);
    checkOutput("rst_d_done",    d_done,    64'd0);
    checkOutput("rst_bus_err",   bus_err,   64'd0);
    checkOutput("rst_stall",     stall,     64'd0);
    arst = 1'b1;
    $display("[TB] reset released");

    // ---------------- single fetch, ack on first BUSY cycle ----------------
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("fetch_stall_waiting", stall, 64'd1);
    waitCycle();                                   // BUSY
    checkOutput("fetch_mem_req",  mem_req,  64'd1);
    checkOutput("fetch_mem_addr", mem_addr, 64'h100);
    checkOutput("fetch_mem_we",   mem_we,   64'd0);
    checkOutput("fetch_no_done",  if_done,  64'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0050_0093;
    waitCycle();                                   // RESP
    checkOutput("fetch_if_done",  if_done,  64'd1);
    checkOutput("fetch_d_done",   d_done,   64'd0);
    checkOutput("fetch_req_drop", mem_req,  64'd0);
    checkOutput("fetch_rdata",    if_rdata, 64'h0050_0093);
    checkOutput("fetch_bus_err",  bus_err,  64'd0);
    checkOutput("fetch_stall_done", stall,  64'd0);
    applyStimulus(1'b0, 32'h0000_0100, 1'b0, 1'b0, '0, '0);
    mem_ack = 1'b0;
    waitCycle();                                   // IDLE
    checkOutput("fetch_done_pulse_end", if_done, 64'd0);

    // ---------------- store with four BUSY cycles ----------------
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF);
    mem_rdata = 32'h1234_5678;
    waitCycle();                                   // BUSY cycle 1
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("store_mem_req_%0d", i),   mem_req,   64'd1);
      checkOutput($sformatf("store_mem_we_%0d", i),    mem_we,    64'd1);
      checkOutput($sformatf("store_mem_addr_%0d", i),  mem_addr,  64'h2000);
      checkOutput($sformatf("store_mem_wdata_%0d", i), mem_wdata, 64'hDEAD_BEEF);
      checkOutput($sformatf("store_no_done_%0d", i),   d_done,    64'd0);
      if (i == 3) begin
        mem_ack = 1'b1;
      end else begin
        waitCycle();
      end
    end
    waitCycle();                                   // RESP
    checkOutput("store_d_done",   d_done,   64'd1);
    checkOutput("store_if_done",  if_done,  64'd0);
    checkOutput("store_bus_err",  bus_err,  64'd0);
    checkOutput("store_req_drop", mem_req,  64'd0);
    checkOutput("store_we_drop",  mem_we,   64'd0);
    checkOutput("store_d_rdata_kept",  d_rdata,  64'd0);
    checkOutput("store_if_rdata_kept", if_rdata, 64'h0050_0093);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0000_2000, 32'hDEAD_BEEF);
    mem_ack = 1'b0;
    waitCycle();                                   // IDLE
    checkOutput("store_done_pulse_end", d_done, 64'd0);

    // ---------------- contention from reset ----------------
    arst = 1'b0;
    waitCycle();
    arst = 1'b1;
    applyStimulus(1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0400, '0);
    for (int k = 0; k < 4; k++) begin
      logic expectFetch;
      expectFetch = (k % 2 == 0);
      waitCycle();                                 // BUSY
      checkOutput($sformatf("cont_addr_%0d", k), mem_addr,
                  expectFetch ? 64'h300 : 64'h400);
      checkOutput($sformatf("cont_req_%0d", k), mem_req, 64'd1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h1000_0000 + k;
      waitCycle();                                 // RESP
      mem_ack = 1'b0;
      checkOutput($sformatf("cont_if_done_%0d", k), if_done, expectFetch ? 64'd1 : 64'd0);
      checkOutput($sformatf("cont_d_done_%0d", k),  d_done,  expectFetch ? 64'd0 : 64'd1);
      if (expectFetch) begin
        checkOutput($sformatf("cont_if_rdata_%0d", k), if_rdata, 64'h1000_0000 + k);
        if_req = 1'b0;
      end else begin
        checkOutput($sformatf("cont_d_rdata_%0d", k), d_rdata, 64'h1000_0000 + k);
        d_req = 1'b0;
      end
      waitCycle();                                 // IDLE
      if (expectFetch) begin
        if_req = 1'b1;
      end else begin
        d_req = 1'b1;
      end
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    waitCycle();

    // ---------------- timeout, no ack ----------------
    applyStimulus(1'b1, 32'h0000_0500, 1'b0, 1'b0, '0, '0);
    mem_rdata = 32'hFFFF_0000;
    waitCycle();                                   // BUSY cycle 1
    reqCycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      reqCycles++;
      waitCycle();
    end
    checkOutput("timeout_req_cycles", reqCycles, 64'd16);
    checkOutput("timeout_if_done",    if_done,   64'd1);
    checkOutput("timeout_bus_err",    bus_err,   64'd1);
    checkOutput("timeout_rdata_kept", if_rdata,  64'h1000_0002);
    if_req = 1'b0;
    waitCycle();
    checkOutput("timeout_done_end", if_done, 64'd0);
    checkOutput("timeout_err_end",  bus_err, 64'd0);

    // ---------------- ack in the 16th BUSY cycle ----------------
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0000_0600, '0);
    waitCycle();                                   // BUSY cycle 1
    for (int i = 0; i < 15; i++) begin
      waitCycle();
    end                                            // BUSY cycle 16
    checkOutput("edge_req_16", mem_req, 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    waitCycle();                                   // RESP
    mem_ack = 1'b0;
    checkOutput("edge_d_done",  d_done,  64'd1);
    checkOutput("edge_bus_err", bus_err, 64'd0);
    checkOutput("edge_d_rdata", d_rdata, 64'hCAFE_F00D);
    d_req = 1'b0;
    waitCycle();

    // ---------------- reset in the middle of an access ----------------
    applyStimulus(1'b0, 32'h0000_0800, 1'b1, 1'b0, 32'h0000_0700, '0);
    waitCycle();                                   // BUSY
    checkOutput("midrst_req_before", mem_req, 64'd1);
    #2;
    arst = 1'b0;
    #1;
    checkOutput("midrst_req_async",  mem_req,  64'd0);
    checkOutput("midrst_addr_async", mem_addr, 64'd0);
    waitCycle();
    checkOutput("midrst_no_done", d_done, 64'd0);
    if_req = 1'b1;
    arst   = 1'b1;
    waitCycle();                                   // BUSY, contention
    checkOutput("midrst_grant_fetch", mem_addr, 64'h800);
    checkOutput("midrst_req_again",   mem_req,  64'd1);
    checkOutput("midrst_still_no_done", d_done, 64'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    waitCycle();                                   // RESP
    mem_ack = 1'b0;
    checkOutput("midrst_if_done", if_done, 64'd1);
    checkOutput("midrst_d_done",  d_done,  64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    waitCycle();
    checkOutput("midrst_done_end", if_done, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
